// File: rtl/ft600_tx_ctrl.sv
// FT600 245-style transmit controller: bursts words from a source FIFO onto the FT600 bus
// through a 2-entry output queue. Optional statistics outputs are enabled by FT600_TX_STATS_EN.
module ft600_tx_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = 2,
  parameter int MAX_BURST  = 64,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [BE_WIDTH+DATA_WIDTH-1:0] fifo_data,
  input  logic                          txe_n,
  output logic                          wr_n,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [BE_WIDTH-1:0]           be_out,
  output logic                          data_oe,
  output logic                          busy
`ifdef FT600_TX_STATS_EN
  ,
  output logic [31:0]                   word_count,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int W = BE_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   q0_q, q0_d, q1_q, q1_d;
  logic [1:0]     occ_q, occ_d;
  logic           in_flight_q, in_flight_d;
  logic [15:0]    issued_q, issued_d;
  logic [7:0]     gap_q, gap_d;
  logic           wr_n_q, wr_n_d;
  logic           data_oe_q, data_oe_d;
  logic           busy_q, busy_d;
  logic           accept_s;
  logic           rd_en_s;
  logic [2:0]     pending_s;
`ifdef FT600_TX_STATS_EN
  logic [31:0]    word_count_q, word_count_d;
  logic [15:0]    underrun_count_q, underrun_count_d;
`endif

  // wr_n_q low implies the queue holds at least one word, so pending_s never underflows
  assign accept_s  = ~wr_n_q & ~txe_n;
  assign pending_s = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, accept_s};
  assign rd_en_s   = (state_q == ACTIVE) && !fifo_empty &&
                     (issued_q < 16'(MAX_BURST)) && (pending_s < 3'd2);

  // Next-state logic for queue, counters, FSM and registered bus outputs
  always_comb begin
    q0_d        = q0_q;
    q1_d        = q1_q;
    occ_d       = occ_q;
    in_flight_d = rd_en_s;
    issued_d    = issued_q + {15'd0, rd_en_s};
    gap_d       = gap_q;
    state_d     = state_q;

    case ({accept_s, in_flight_q})
      2'b11: begin
        if (occ_q == 2'd2) begin
          q0_d = q1_q;
          q1_d = fifo_data;
        end else begin
          q0_d = fifo_data;
        end
      end
      2'b10: begin
        q0_d  = q1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) begin
          q0_d = fifo_data;
        end else begin
          q1_d = fifo_data;
        end
        occ_d = occ_q + 2'd1;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase

    // Transitions look at next-cycle queue state so no idle cycle is wasted after the last pop
    case (state_q)
      IDLE: begin
        issued_d = 16'd0;
        if (!fifo_empty && !txe_n) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (issued_d == 16'(MAX_BURST)) begin
          state_d = DRAIN;
        end else if (fifo_empty && (occ_d == 2'd0) && !in_flight_d) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      DRAIN: begin
        if ((occ_d == 2'd0) && !in_flight_d) begin
          state_d = GAP;
          gap_d   = 8'd0;
        end else begin
          state_d = DRAIN;
        end
      end
      GAP: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    data_oe_d = (state_d == ACTIVE) || (state_d == DRAIN);
    wr_n_d    = !(data_oe_d && (occ_d != 2'd0));
    busy_d    = (state_d != IDLE);
  end

`ifdef FT600_TX_STATS_EN
  // Statistics: accepted words wrap, underruns saturate
  always_comb begin
    word_count_d     = word_count_q + {31'd0, accept_s};
    underrun_count_d = underrun_count_q;
    if ((state_q == ACTIVE) && (state_d == IDLE) && (underrun_count_q != 16'hFFFF)) begin
      underrun_count_d = underrun_count_q + 16'd1;
    end else begin
      underrun_count_d = underrun_count_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count_q     <= 32'd0;
      underrun_count_q <= 16'd0;
    end else begin
      word_count_q     <= word_count_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign word_count     = word_count_q;
  assign underrun_count = underrun_count_q;
`endif

  // State, queue and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q0_q        <= '0;
      q1_q        <= '0;
      occ_q       <= 2'd0;
      in_flight_q <= 1'b0;
      issued_q    <= 16'd0;
      gap_q       <= 8'd0;
      wr_n_q      <= 1'b1;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      occ_q       <= occ_d;
      in_flight_q <= in_flight_d;
      issued_q    <= issued_d;
      gap_q       <= gap_d;
      wr_n_q      <= wr_n_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign wr_n       = wr_n_q;
  assign data_oe    = data_oe_q;
  assign busy       = busy_q;
  assign data_out   = q0_q[DATA_WIDTH-1:0];
  assign be_out     = q0_q[W-1:DATA_WIDTH];

endmodule

// File: tb/tb_ft600_tx_ctrl.sv
// Directed self-checking bench for ft600_tx_ctrl: a default instance (a) and a short-burst
// instance (b, MAX_BURST=4, GAP_CYCLES=4), each fed by a small FIFO model.
module tb_ft600_tx_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic        fifo_empty_a, fifo_rd_en_a, txe_n_a, wr_n_a, data_oe_a, busy_a;
  logic [17:0] fifo_data_a = 18'd0;
  logic [15:0] data_a;
  logic [1:0]  be_a;
  logic        fifo_empty_b, fifo_rd_en_b, txe_n_b, wr_n_b, data_oe_b, busy_b;
  logic [17:0] fifo_data_b = 18'd0;
  logic [15:0] data_b;
  logic [1:0]  be_b;
`ifdef FT600_TX_STATS_EN
  logic [31:0] word_count_a, word_count_b;
  logic [15:0] underrun_count_a, underrun_count_b;
`endif

  ft600_tx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_a), .fifo_rd_en(fifo_rd_en_a),
    .fifo_data(fifo_data_a), .txe_n(txe_n_a), .wr_n(wr_n_a), .data_out(data_a),
    .be_out(be_a), .data_oe(data_oe_a), .busy(busy_a)
`ifdef FT600_TX_STATS_EN
    , .word_count(word_count_a), .underrun_count(underrun_count_a)
`endif
  );

  ft600_tx_ctrl #(.MAX_BURST(4), .GAP_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_b), .fifo_rd_en(fifo_rd_en_b),
    .fifo_data(fifo_data_b), .txe_n(txe_n_b), .wr_n(wr_n_b), .data_out(data_b),
    .be_out(be_b), .data_oe(data_oe_b), .busy(busy_b)
`ifdef FT600_TX_STATS_EN
    , .word_count(word_count_b), .underrun_count(underrun_count_b)
`endif
  );

  // FIFO models: data appears one edge after the read edge
  logic [17:0] mem_a [0:255];
  logic [17:0] mem_b [0:255];
  int wa = 0, ra = 0, wb = 0, rb = 0;
  assign fifo_empty_a = (wa == ra);
  assign fifo_empty_b = (wb == rb);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en_a) begin
      fifo_data_a <= mem_a[ra[7:0]];
      ra <= ra + 1;
    end
    if (fifo_rd_en_b) begin
      fifo_data_b <= mem_b[rb[7:0]];
      rb <= rb + 1;
    end
  end

  // Accept loggers: word and cycle of every accept edge
  logic [17:0] acc_a [0:255];
  int          acc_cyc_a [0:255];
  int          na = 0;
  logic [17:0] acc_b [0:255];
  int          acc_cyc_b [0:255];
  int          nb = 0;

  always @(posedge clk) begin
    if (rst_n && !wr_n_a && !txe_n_a) begin
      acc_a[na[7:0]]     <= {be_a, data_a};
      acc_cyc_a[na[7:0]] <= cyc;
      na <= na + 1;
    end
    if (rst_n && !wr_n_b && !txe_n_b) begin
      acc_b[nb[7:0]]     <= {be_b, data_b};
      acc_cyc_b[nb[7:0]] <= cyc;
      nb <= nb + 1;
    end
  end

  task automatic push_a(input logic [17:0] w);
    mem_a[wa[7:0]] = w;
    wa = wa + 1;
  endtask

  task automatic push_b(input logic [17:0] w);
    mem_b[wb[7:0]] = w;
    wb = wb + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    wa = ra;
    wb = rb;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_na(input int tgt, input int budget, input string name);
    for (int i = 0; i < budget && na < tgt; i++) @(negedge clk);
    vectors++;
    if (na < tgt) begin
      miscompares++;
      $display("FAIL %s timeout: accepts %0d, required %0d", name, na, tgt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    txe_n_a = 1'b0;
    txe_n_b = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wr_n_a, data_oe_a, busy_a, fifo_rd_en_a, be_a, data_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_a: got wr_n=%b oe=%b busy=%b rd=%b be=%b d=%h, required 1 0 0 0 00 0000",
               wr_n_a, data_oe_a, busy_a, fifo_rd_en_a, be_a, data_a);
    end
    vectors++;
    if ({wr_n_b, data_oe_b, busy_b, fifo_rd_en_b} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_b: got %b, required 1000", {wr_n_b, data_oe_b, busy_b, fifo_rd_en_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int base;
    base = na;
    for (int k = 0; k < 8; k++) push_a({2'b11, 16'(k)});
    wait_na(base + 8, 60, "stream");
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (acc_a[base + k] !== {2'b11, 16'(k)}) begin
        miscompares++;
        $display("FAIL stream_word%0d: got %h, required %h", k, acc_a[base + k], {2'b11, 16'(k)});
      end
    end
    vectors++;
    if (acc_cyc_a[base + 7] - acc_cyc_a[base] !== 7) begin
      miscompares++;
      $display("FAIL stream_rate: span %0d cycles, required 7", acc_cyc_a[base + 7] - acc_cyc_a[base]);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy_a, wr_n_a, na} !== {1'b0, 1'b1, base + 8}) begin
      miscompares++;
      $display("FAIL stream_idle: got busy=%b wr_n=%b accepts=%0d, required 0 1 %0d", busy_a, wr_n_a, na, base + 8);
    end
  endtask

  task automatic test_stall();
    int base;
    base = na;
    for (int k = 0; k < 10; k++) push_a({2'b11, 16'(k)});
    wait_na(base + 2, 40, "stall_start");
    txe_n_a = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      vectors++;
      if ({wr_n_a, data_a, na} !== {1'b0, 16'h0002, base + 2}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got wr_n=%b d=%h accepts=%0d, required 0 0002 %0d", s, wr_n_a, data_a, na, base + 2);
      end
    end
    txe_n_a = 1'b0;
    wait_na(base + 10, 40, "stall_finish");
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (acc_a[base + k] !== {2'b11, 16'(k)}) begin
        miscompares++;
        $display("FAIL stall_word%0d: got %h, required %h", k, acc_a[base + k], {2'b11, 16'(k)});
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (na !== base + 10) begin
      miscompares++;
      $display("FAIL stall_count: got %0d accepts, required %0d", na - base, 10);
    end
  endtask

  task automatic test_burst();
    int base, gap_cycles, gap_bad;
    base = nb;
    gap_cycles = 0;
    gap_bad = 0;
    for (int k = 0; k < 10; k++) push_b({2'b11, 16'(16'h0010 + k)});
    for (int i = 0; i < 120 && !(nb >= base + 10 && !busy_b); i++) begin
      @(negedge clk);
      if (busy_b && !data_oe_b) begin
        gap_cycles++;
        if (!wr_n_b || fifo_rd_en_b) gap_bad++;
      end
    end
    vectors++;
    if (nb !== base + 10) begin
      miscompares++;
      $display("FAIL burst_count: got %0d accepts, required 10", nb - base);
    end
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (acc_b[base + k] !== {2'b11, 16'(16'h0010 + k)}) begin
        miscompares++;
        $display("FAIL burst_word%0d: got %h, required %h", k, acc_b[base + k], {2'b11, 16'(16'h0010 + k)});
      end
    end
    // 4 back-to-back accepts, 4 GAP cycles, then IDLE->ACTIVE plus 3-edge fill latency
    vectors++;
    if ({acc_cyc_b[base + 3] - acc_cyc_b[base], acc_cyc_b[base + 4] - acc_cyc_b[base + 3],
         acc_cyc_b[base + 8] - acc_cyc_b[base + 7], acc_cyc_b[base + 9] - acc_cyc_b[base + 8]} !== {32'd3, 32'd8, 32'd8, 32'd1}) begin
      miscompares++;
      $display("FAIL burst_timing: spans %0d %0d %0d %0d, required 3 8 8 1",
               acc_cyc_b[base + 3] - acc_cyc_b[base], acc_cyc_b[base + 4] - acc_cyc_b[base + 3],
               acc_cyc_b[base + 8] - acc_cyc_b[base + 7], acc_cyc_b[base + 9] - acc_cyc_b[base + 8]);
    end
    vectors++;
    if ({gap_cycles, gap_bad} !== {32'd8, 32'd0}) begin
      miscompares++;
      $display("FAIL burst_gap: got %0d gap cycles with %0d bus violations, required 8 and 0", gap_cycles, gap_bad);
    end
  endtask

  task automatic test_reset_mid();
    int base, rd_mark, na_mark;
    base = na;
    for (int k = 0; k < 8; k++) push_a({2'b11, 16'(16'h0040 + k)});
    wait_na(base + 3, 40, "rstmid_start");
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wr_n_a, data_oe_a, data_a, be_a, busy_a} !== {1'b1, 1'b0, 16'h0000, 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_bus: got wr_n=%b oe=%b d=%h be=%b busy=%b, required 1 0 0000 00 0",
               wr_n_a, data_oe_a, data_a, be_a, busy_a);
    end
    rd_mark = ra;
    na_mark = na;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ra, na, fifo_rd_en_a} !== {rd_mark, na_mark, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_reads: got rd_ptr=%0d accepts=%0d rd_en=%b, required %0d %0d 0",
               ra, na, fifo_rd_en_a, rd_mark, na_mark);
    end
    wa = ra;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_underrun();
    int base, falls;
    logic prev;
    base = na;
    falls = 0;
    prev = busy_a;
    for (int k = 0; k < 4; k++) push_a({2'b11, 16'(16'h0020 + k)});
    for (int i = 0; i < 40 && na < base + 4; i++) begin
      @(negedge clk);
      if (prev && !busy_a) falls++;
      prev = busy_a;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (prev && !busy_a) falls++;
      prev = busy_a;
    end
    vectors++;
    if ({falls, busy_a, na} !== {32'd1, 1'b0, base + 4}) begin
      miscompares++;
      $display("FAIL underrun_idle: got falls=%0d busy=%b accepts=%0d, required 1 0 %0d", falls, busy_a, na - base, 4);
    end
`ifdef FT600_TX_STATS_EN
    vectors++;
    if (underrun_count_a !== 16'd1) begin
      miscompares++;
      $display("FAIL underrun_stat: got %0d, required 1", underrun_count_a);
    end
`endif
    for (int k = 4; k < 8; k++) push_a({2'b11, 16'(16'h0020 + k)});
    wait_na(base + 8, 40, "underrun_resume");
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (acc_a[base + k] !== {2'b11, 16'(16'h0020 + k)}) begin
        miscompares++;
        $display("FAIL underrun_word%0d: got %h, required %h", k, acc_a[base + k], {2'b11, 16'(16'h0020 + k)});
      end
    end
`ifdef FT600_TX_STATS_EN
    @(negedge clk);
    vectors++;
    if (word_count_a !== 32'd8) begin
      miscompares++;
      $display("FAIL word_stat: got %0d, required 8", word_count_a);
    end
`endif
  endtask

  task automatic test_be();
    int base;
    base = na;
    push_a({2'b11, 16'h0030});
    push_a({2'b11, 16'h0031});
    push_a({2'b01, 16'h0032});
    wait_na(base + 3, 30, "be");
    vectors++;
    if ({acc_a[base], acc_a[base + 1], acc_a[base + 2]} !== {2'b11, 16'h0030, 2'b11, 16'h0031, 2'b01, 16'h0032}) begin
      miscompares++;
      $display("FAIL be_last: got %h %h %h, required 30030 30031 10032", acc_a[base], acc_a[base + 1], acc_a[base + 2]);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    do_reset();
    test_stall();
    do_reset();
    test_burst();
    do_reset();
    test_reset_mid();
    do_reset();
    test_underrun();
    do_reset();
    test_be();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ft600_tx_ctrl.md
FT600_TX_CTRL -- requirements
Module: ft600_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, FT600 bus data width.
REQ-002 SHALL have parameter BE_WIDTH, default 2, byte-enable width; FIFO word = {BE, DATA} = 18 bits.
REQ-003 SHALL have parameter MAX_BURST, default 64, max FIFO reads issued per burst (range 1..65535).
REQ-004 SHALL have parameter GAP_CYCLES, default 4, idle cycles between bursts (range 1..255).
REQ-005 SHALL have ports: clk input 1 (clock, all logic on rising edge); rst_n input 1 (reset, synchronous, active-low).
REQ-006 SHALL have ports: fifo_empty input 1 (source FIFO empty); fifo_rd_en output 1 (FIFO read request); fifo_data input BE_WIDTH+DATA_WIDTH (FIFO read data, valid one edge after a rd_en edge).
REQ-007 SHALL have ports: txe_n input 1 (FT600 can accept, active-low); wr_n output 1 (write strobe, active-low); data_out output DATA_WIDTH; be_out output BE_WIDTH; data_oe output 1 (bus drive enable); busy output 1 (state != IDLE).

Function
REQ-008 SHALL implement states IDLE, ACTIVE, DRAIN, GAP.
REQ-009 SHALL move IDLE->ACTIVE when fifo_empty=0 and txe_n=0; clear issue counter on entry.
REQ-010 SHALL hold a 2-entry output queue; head drives data_out/be_out; data_out = fifo_data[DATA_WIDTH-1:0], be_out = fifo_data[top BE_WIDTH bits].
REQ-011 SHALL assert wr_n=0 iff state is ACTIVE or DRAIN and queue non-empty; data_oe=1 iff state is ACTIVE or DRAIN.
REQ-012 SHALL define accept = (wr_n=0 and txe_n=0) at a rising edge; accept pops queue head; no other event pops.
REQ-013 SHALL drive fifo_rd_en (combinational) = ACTIVE and fifo_empty=0 and issued<MAX_BURST and (occupancy + in_flight - accept) < 2.
REQ-014 SHALL capture fifo_data into queue tail exactly one edge after each edge where fifo_rd_en=1 (in_flight flag); simultaneous push and pop SHALL keep occupancy.
REQ-015 SHALL sustain one word per cycle while txe_n=0 and FIFO non-empty.
REQ-016 SHALL hold head word and wr_n=0 unchanged while txe_n=1; no word lost or duplicated.
REQ-017 SHALL move ACTIVE->DRAIN when issued reaches MAX_BURST.
REQ-018 SHALL move ACTIVE->IDLE when fifo_empty=1, queue empty, no read in flight (underrun).
REQ-019 SHALL move DRAIN->GAP when queue empty and no read in flight; GAP SHALL last exactly GAP_CYCLES cycles, then IDLE.
REQ-020 SHALL never assert fifo_rd_en in IDLE, DRAIN or GAP.

Reset
REQ-021 SHALL, with rst_n=0 at a rising edge: state=IDLE, wr_n=1, data_oe=0, data_out=0, be_out=0, fifo_rd_en=0, queue/in_flight/counters=0.
REQ-022 SHALL on reset mid-burst discard queued and in-flight words; wr_n=1 on the first edge of reset.

Configuration
REQ-023 SHALL, with macro FT600_TX_STATS_EN defined, add outputs word_count (32 bits, increments per accept, wraps) and underrun_count (16 bits, increments per ACTIVE->IDLE, saturates at 0xFFFF), both cleared by reset.
REQ-024 SHALL, without FT600_TX_STATS_EN, have neither port nor counter logic; other behaviour identical.

Verification
REQ-025 SHALL cover: FIFO preloaded 8 words 0x0000..0x0007, BE=2'b11, txe_n=0 -> 8 accepts on consecutive cycles, order preserved, then IDLE.
REQ-026 SHALL cover: 10 words, txe_n=1 for 3 cycles after 2nd accept -> head 0x0002 held 3 cycles, all 10 delivered once.
REQ-027 SHALL cover: MAX_BURST=4, GAP_CYCLES=4, 10 words -> bursts 4,4,2 accepts, exactly 4 GAP cycles between bursts with wr_n=1, fifo_rd_en=0.
REQ-028 SHALL cover: rst_n=0 after 3 of 8 accepts -> wr_n=1, data_oe=0, data_out=0 next edge, no further reads until released.
REQ-029 SHALL cover: FIFO writes stall 5 cycles mid-stream -> ACTIVE->IDLE once, resume on refill; with FT600_TX_STATS_EN underrun_count=1.
REQ-030 SHALL cover: BE=2'b01 on final word -> be_out=2'b01 during that accept only.
